// File: rtl/data_memory.sv
// Data memory stage: single-port RAM with write-first reads, a memory-mapped
// output register and a synchronized input port. Self-clears the RAM after reset.
//
// state | meaning
// INIT  | sweeping clr_cnt over the RAM writing zeros; busy_o high, w_i ignored
// RUN   | normal load/store operation; left only by reset
module data_memory #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] IO_OUT_ADDR = 8'hFF,
    parameter logic [ADDR_W-1:0] IO_IN_ADDR  = 8'hFE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              w_i,
    input  logic [DATA_W-1:0] in_port_i,
    output logic [DATA_W-1:0] data_o,
    output logic [DATA_W-1:0] out_port_o,
    output logic              busy_o
);

    localparam logic [0:0]        ST_INIT  = 1'b0;
    localparam logic [0:0]        ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] sync_q1;
    logic [DATA_W-1:0] sync_q2;

    logic [DATA_W-1:0] ram [0:2**ADDR_W-1];

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    logic              is_io_out;
    logic              is_io_in;

    assign is_io_out = (addr_i == IO_OUT_ADDR);
    assign is_io_in  = (addr_i == IO_IN_ADDR);
    assign busy_o    = (state == ST_INIT);

    // During INIT the clear counter owns the write port; IO addresses never reach the RAM.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = addr_i;
        ram_wdata = data_i;
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = '0;
        end else if (w_i && !is_io_out && !is_io_in) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_INIT;
            clr_cnt    <= '0;
            data_o     <= '0;
            out_port_o <= '0;
            sync_q1    <= '0;
            sync_q2    <= '0;
        end else begin
            sync_q1 <= in_port_i;
            sync_q2 <= sync_q1;
            if (state == ST_INIT) begin
                clr_cnt <= clr_cnt + 1'b1;
                data_o  <= '0;
                if (clr_cnt == CLR_LAST) begin
                    state <= ST_RUN;
                end
            end else begin
                if (w_i && is_io_out) begin
                    out_port_o <= data_i;
                end
                // Write-first: a same-cycle write is forwarded, except to the read-only input port.
                if (is_io_in) begin
                    data_o <= sync_q2;
                end else if (w_i) begin
                    data_o <= data_i;
                end else if (is_io_out) begin
                    data_o <= out_port_o;
                end else begin
                    data_o <= ram[addr_i];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: clear sequence, load/store, write-first,
// memory-mapped IO ports and reset during the clear sequence.
module tb_data_memory;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] addr_i;
    logic [7:0] data_i;
    logic       w_i;
    logic [7:0] in_port_i;
    logic [7:0] data_o;
    logic [7:0] out_port_o;
    logic       busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n_busy;

    data_memory dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .w_i        (w_i),
        .in_port_i  (in_port_i),
        .data_o     (data_o),
        .out_port_o (out_port_o),
        .busy_o     (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one access at a negedge and return at the next negedge, after its edge.
    task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic w);
        addr_i = a;
        data_i = d;
        w_i    = w;
        @(negedge clk_i);
    endtask

    // Counts rising edges until busy_o drops; returns #1 after that edge.
    task automatic count_busy(output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk_i);
            n++;
            #1;
            if (!busy_o) break;
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        addr_i    = 8'h00;
        data_i    = 8'h00;
        w_i       = 1'b0;
        in_port_i = 8'h00;
        repeat (3) @(negedge clk_i);
        check_eq("rst_data", data_o, 8'h00);
        check_eq("rst_out", out_port_o, 8'h00);
        check_eq("rst_busy", {7'b0, busy_o}, 8'h01);

        rst_i = 1'b0;
        count_busy(n_busy);
        check_eq("init_len", n_busy[7:0], 8'h00);
        check_eq("init_len_hi", {7'b0, n_busy[8]}, 8'h01);
        check_eq("init_data", data_o, 8'h00);
        @(negedge clk_i);

        cyc(8'h10, 8'h00, 1'b0);
        check_eq("rd_cleared", data_o, 8'h00);

        cyc(8'h10, 8'hA5, 1'b1);
        cyc(8'h10, 8'h00, 1'b0);
        check_eq("rd_10", data_o, 8'hA5);
        cyc(8'h11, 8'h00, 1'b0);
        check_eq("rd_11", data_o, 8'h00);

        cyc(8'h20, 8'h3C, 1'b1);
        check_eq("rdw_20", data_o, 8'h3C);
        cyc(8'h20, 8'h00, 1'b0);
        check_eq("rd_20", data_o, 8'h3C);

        cyc(8'hFF, 8'h5A, 1'b1);
        check_eq("out_wr", out_port_o, 8'h5A);
        check_eq("out_rdw", data_o, 8'h5A);
        cyc(8'hFF, 8'h00, 1'b0);
        check_eq("out_rd", data_o, 8'h5A);
        cyc(8'hFE, 8'h77, 1'b1);
        check_eq("in_wr_out", out_port_o, 8'h5A);
        check_eq("in_wr_data", data_o, 8'h00);
        cyc(8'hFF, 8'h00, 1'b0);
        check_eq("out_rd2", data_o, 8'h5A);
        cyc(8'h10, 8'h00, 1'b0);
        check_eq("rd_10_b", data_o, 8'hA5);

        addr_i = 8'hFE;
        w_i    = 1'b0;
        @(negedge clk_i);
        in_port_i = 8'h81;
        @(negedge clk_i);
        check_eq("sync_e1", data_o, 8'h00);
        @(negedge clk_i);
        @(negedge clk_i);
        check_eq("sync_e3", data_o, 8'h81);
        @(negedge clk_i);
        check_eq("sync_e4", data_o, 8'h81);

        rst_i = 1'b1;
        #1;
        check_eq("rrun_data", data_o, 8'h00);
        check_eq("rrun_out", out_port_o, 8'h00);
        check_eq("rrun_busy", {7'b0, busy_o}, 8'h01);
        @(negedge clk_i);
        addr_i = 8'hFF;
        data_i = 8'h99;
        w_i    = 1'b1;
        rst_i  = 1'b0;
        repeat (100) @(negedge clk_i);
        check_eq("init_out", out_port_o, 8'h00);
        check_eq("init_data2", data_o, 8'h00);
        check_eq("init_busy", {7'b0, busy_o}, 8'h01);

        rst_i = 1'b1;
        #1;
        check_eq("rinit_busy", {7'b0, busy_o}, 8'h01);
        check_eq("rinit_data", data_o, 8'h00);
        @(negedge clk_i);
        addr_i = 8'h05;
        data_i = 8'hEE;
        w_i    = 1'b1;
        rst_i  = 1'b0;
        count_busy(n_busy);
        w_i = 1'b0;
        check_eq("reinit_len", n_busy[7:0], 8'h00);
        check_eq("reinit_len_hi", {7'b0, n_busy[8]}, 8'h01);
        @(negedge clk_i);
        cyc(8'h05, 8'h00, 1'b0);
        check_eq("rd_05", data_o, 8'h00);
        cyc(8'h10, 8'h00, 1'b0);
        check_eq("rd_10_clr", data_o, 8'h00);
        cyc(8'hFF, 8'h00, 1'b0);
        check_eq("out_after", data_o, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
